// File: rtl/auction_bidder10.sv
// Bid generation/update engine feeding a 10-way argmax selector.
// Each round presents the bids, takes the registered winner, penalises it and ages the losers.
module auction_bidder10 #(
  parameter int bW      = 17,
  parameter int ROUND_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_valid_i,
  output logic               load_ready_o,
  input  logic [3:0]         load_idx_i,
  input  logic [bW-1:0]      load_bid_i,
  input  logic               start_i,
  input  logic [ROUND_W-1:0] rounds_i,
  input  logic [bW-1:0]      penalty_i,
  input  logic [bW-1:0]      age_step_i,
  output logic [bW-1:0]      bids_out_o [10],
  input  logic [3:0]         win_in_i,
  output logic               grant_valid_o,
  output logic [3:0]         grant_idx_o,
  output logic [9:0]         grant_onehot_o,
  output logic               busy_o,
  output logic               done_o
);

  typedef enum logic [1:0] {IDLE, ISSUE, SAMPLE, DONE} state_e;

  state_e             state_q, state_d;
  logic [bW-1:0]      bids_q [10];
  logic [bW-1:0]      bids_d [10];
  logic [bW:0]        agedSum [10];
  logic [ROUND_W-1:0] rounds_q, roundCnt_q, roundCnt_d, roundNext;
  logic [bW-1:0]      penalty_q, ageStep_q;
  logic               grantValid_q, grantValid_d;
  logic [3:0]         grantIdx_q, grantIdx_d;
  logic               winValid, loadFire, startRun;

  assign winValid  = (win_in_i < 4'd10);
  assign loadFire  = load_valid_i && load_ready_o && (load_idx_i < 4'd10);
  assign startRun  = (state_q == IDLE) && start_i && (rounds_i != '0);
  assign roundNext = roundCnt_q + ROUND_W'(1);

  // Extra carry bit lets the aged value saturate instead of wrapping.
  for (genvar g = 0; g < 10; g++) begin : g_age
    assign agedSum[g]    = {1'b0, bids_q[g]} + {1'b0, ageStep_q};
    assign bids_out_o[g] = bids_q[g];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_i) state_d = (rounds_i != '0) ? ISSUE : DONE;
      ISSUE:   state_d = SAMPLE;
      SAMPLE:  state_d = (roundNext == rounds_q) ? DONE : ISSUE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    load_ready_o = (state_q == IDLE);
    busy_o       = (state_q == ISSUE) || (state_q == SAMPLE);
    done_o       = (state_q == DONE);
  end

  always_comb begin
    roundCnt_d   = roundCnt_q;
    grantValid_d = 1'b0;
    grantIdx_d   = grantIdx_q;
    for (int i = 0; i < 10; i++) bids_d[i] = bids_q[i];
    if (state_q == IDLE) begin
      for (int i = 0; i < 10; i++)
        if (loadFire && (load_idx_i == 4'(i))) bids_d[i] = load_bid_i;
      if (startRun) roundCnt_d = '0;
    end else if (state_q == SAMPLE) begin
      roundCnt_d = roundNext;
      // An out-of-range winner still consumes the round but leaves bids untouched.
      if (winValid) begin
        grantValid_d = 1'b1;
        grantIdx_d   = win_in_i;
        for (int i = 0; i < 10; i++) begin
          if (win_in_i == 4'(i))
            bids_d[i] = (bids_q[i] > penalty_q) ? bids_q[i] - penalty_q : '0;
          else
            bids_d[i] = agedSum[i][bW] ? '1 : agedSum[i][bW-1:0];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 10; i++) bids_q[i] <= '0;
      rounds_q     <= '0;
      roundCnt_q   <= '0;
      penalty_q    <= '0;
      ageStep_q    <= '0;
      grantValid_q <= 1'b0;
      grantIdx_q   <= '0;
    end else begin
      for (int i = 0; i < 10; i++) bids_q[i] <= bids_d[i];
      roundCnt_q   <= roundCnt_d;
      grantValid_q <= grantValid_d;
      grantIdx_q   <= grantIdx_d;
      if (startRun) begin
        rounds_q  <= rounds_i;
        penalty_q <= penalty_i;
        ageStep_q <= age_step_i;
      end
    end
  end

  assign grant_valid_o  = grantValid_q;
  assign grant_idx_o    = grantIdx_q;
  assign grant_onehot_o = grantValid_q ? (10'b1 << grantIdx_q) : 10'b0;

endmodule

// File: tb/tb_auction_bidder10.sv
// Self-checking bench for auction_bidder10: vector table, multi-cycle sequences,
// a grant scoreboard and a behavioural argmax selector for the closed-loop run.
module tb_auction_bidder10;
  localparam int  bW   = 17;
  localparam longint MAXB = (longint'(1) << bW) - 1;

  typedef logic [bW-1:0] bidArr_t [10];
  typedef struct {
    bidArr_t       initBids;
    logic [bW-1:0] pen;
    logic [bW-1:0] age;
    logic [3:0]    win;
    bidArr_t       expBids;
    logic          expGrant;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          load_valid;
  logic          load_ready;
  logic [3:0]    load_idx;
  logic [bW-1:0] load_bid;
  logic          start;
  logic [7:0]    rounds;
  logic [bW-1:0] penalty;
  logic [bW-1:0] age_step;
  logic [bW-1:0] bids_out [10];
  logic [3:0]    win_in;
  logic          grant_valid;
  logic [3:0]    grant_idx;
  logic [9:0]    grant_onehot;
  logic          busy;
  logic          done;

  logic          closedLoop;
  logic [3:0]    manualWin;
  logic [3:0]    selWin;
  logic [3:0]    expQ [$];
  logic [3:0]    popIdx;
  logic [9:0]    popOh;
  int            compared   = 0;
  int            mismatched = 0;
  int            grantsSeen = 0;
  vec_t          vecs [4];
  bidArr_t       model;

  always #5 clk = ~clk;

  auction_bidder10 #(.bW(bW), .ROUND_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .load_valid_i(load_valid), .load_ready_o(load_ready),
    .load_idx_i(load_idx), .load_bid_i(load_bid),
    .start_i(start), .rounds_i(rounds), .penalty_i(penalty), .age_step_i(age_step),
    .bids_out_o(bids_out), .win_in_i(win_in),
    .grant_valid_o(grant_valid), .grant_idx_o(grant_idx), .grant_onehot_o(grant_onehot),
    .busy_o(busy), .done_o(done)
  );

  function automatic logic [3:0] argmax(input bidArr_t b);
    int best = 0;
    for (int i = 1; i < 10; i++) if (b[i] > b[best]) best = i;
    return 4'(best);
  endfunction

  function automatic bidArr_t modelUpdate(input bidArr_t b, input int win, input longint pen,
                                          input longint age);
    bidArr_t r;
    longint  x;
    for (int i = 0; i < 10; i++) begin
      if (i == win) x = (longint'(b[i]) > pen) ? longint'(b[i]) - pen : 0;
      else begin
        x = longint'(b[i]) + age;
        if (x > MAXB) x = MAXB;
      end
      r[i] = bW'(x);
    end
    return r;
  endfunction

  // Behavioural selector: registered argmax, lowest index wins ties.
  always @(posedge clk) selWin <= argmax(bids_out);
  assign win_in = closedLoop ? selWin : manualWin;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard: every observed grant must match the oldest expected winner.
  always @(negedge clk) begin
    if (rst_n && grant_valid) begin
      grantsSeen++;
      if (expQ.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL unexpected_grant: got grant_idx=%0d expected no grant", grant_idx);
      end else begin
        popIdx = expQ.pop_front();
        popOh  = 10'b1 << popIdx;
        checkOutput("grant_idx", 32'(grant_idx), 32'(popIdx));
        checkOutput("grant_onehot", 32'(grant_onehot), 32'(popOh));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkBids(input string name, input bidArr_t exp);
    for (int i = 0; i < 10; i++) checkOutput(name, 32'(bids_out[i]), 32'(exp[i]));
  endtask

  task automatic checkReset();
    bidArr_t z;
    for (int i = 0; i < 10; i++) z[i] = '0;
    checkOutput("rst_grant_valid", 32'(grant_valid), 32'd0);
    checkOutput("rst_grant_idx", 32'(grant_idx), 32'd0);
    checkOutput("rst_grant_onehot", 32'(grant_onehot), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_load_ready", 32'(load_ready), 32'd1);
    checkBids("rst_bids", z);
  endtask

  task automatic applyStimulus(input int idx, input logic [bW-1:0] val);
    load_valid = 1'b1;
    load_idx   = 4'(idx);
    load_bid   = val;
    tick();
    load_valid = 1'b0;
  endtask

  task automatic runVector(input vec_t v);
    for (int i = 0; i < 9; i++) applyStimulus(i, v.initBids[i]);
    // Last slot is written in the same cycle that start is accepted.
    load_valid = 1'b1; load_idx = 4'd9; load_bid = v.initBids[9];
    start = 1'b1; rounds = 8'd1; penalty = v.pen; age_step = v.age; manualWin = v.win;
    if (v.expGrant) expQ.push_back(v.win);
    tick();
    load_valid = 1'b0; start = 1'b0;
    checkOutput("vec_busy_E0", 32'(busy), 32'd1);
    checkOutput("vec_ready_E0", 32'(load_ready), 32'd0);
    tick();
    tick();
    checkOutput("vec_done_E2", 32'(done), 32'd1);
    checkOutput("vec_busy_E2", 32'(busy), 32'd0);
    checkOutput("vec_gvalid_E2", 32'(grant_valid), 32'(v.expGrant));
    checkBids("vec_bids", v.expBids);
    tick();
    checkOutput("vec_done_E3", 32'(done), 32'd0);
    checkOutput("vec_ready_E3", 32'(load_ready), 32'd1);
    checkOutput("vec_onehot_E3", 32'(grant_onehot), 32'd0);
  endtask

  initial begin
    int gBefore;
    logic [3:0] w;
    bidArr_t afterTable;

    for (int i = 0; i < 10; i++) begin
      vecs[0].initBids[i] = bW'(10 * i);
      vecs[0].expBids[i]  = (i == 9) ? '0 : bW'(10 * i + 1);
      vecs[1].initBids[i] = '0;
      vecs[1].expBids[i]  = bW'(5);
      vecs[2].initBids[i] = (i == 0) ? bW'(5) : bW'(1000 + i);
      vecs[2].expBids[i]  = (i == 0) ? '0 : bW'(1002 + i);
      vecs[3].initBids[i] = bW'(7 * i + 3);
      vecs[3].expBids[i]  = bW'(7 * i + 3);
    end
    vecs[1].initBids[3] = 17'h1FFFF; vecs[1].expBids[3] = 17'h1FFFF;
    vecs[1].initBids[5] = 17'h1FFFE; vecs[1].expBids[5] = 17'h1FFFF;
    vecs[1].initBids[7] = 17'd2;     vecs[1].expBids[7] = 17'd0;
    vecs[0].pen = 17'd100; vecs[0].age = 17'd1; vecs[0].win = 4'd9;  vecs[0].expGrant = 1'b1;
    vecs[1].pen = 17'd3;   vecs[1].age = 17'd5; vecs[1].win = 4'd7;  vecs[1].expGrant = 1'b1;
    vecs[2].pen = 17'd5;   vecs[2].age = 17'd2; vecs[2].win = 4'd0;  vecs[2].expGrant = 1'b1;
    vecs[3].pen = 17'd1;   vecs[3].age = 17'd1; vecs[3].win = 4'd12; vecs[3].expGrant = 1'b0;
    afterTable = vecs[3].expBids;

    rst_n = 1'b0; load_valid = 1'b0; load_idx = '0; load_bid = '0; start = 1'b0;
    rounds = '0; penalty = '0; age_step = '0; closedLoop = 1'b0; manualWin = '0;
    #12;
    checkReset();
    tick();
    rst_n = 1'b1;
    tick();

    for (int v = 0; v < 4; v++) runVector(vecs[v]);

    $display("[TB] rounds==0 start");
    start = 1'b1; rounds = 8'd0;
    tick();
    start = 1'b0;
    checkOutput("r0_done_E0", 32'(done), 32'd1);
    checkOutput("r0_busy_E0", 32'(busy), 32'd0);
    checkOutput("r0_ready_E0", 32'(load_ready), 32'd0);
    tick();
    checkOutput("r0_done_E1", 32'(done), 32'd0);
    checkOutput("r0_ready_E1", 32'(load_ready), 32'd1);
    checkBids("r0_bids", afterTable);

    $display("[TB] out-of-range load index");
    applyStimulus(11, 17'h1234);
    checkBids("idx11_bids", afterTable);

    $display("[TB] loads and start ignored during a 3-round run");
    model = afterTable;
    for (int k = 0; k < 3; k++) begin
      expQ.push_back(4'd4);
      model = modelUpdate(model, 4, 2, 3);
    end
    start = 1'b1; rounds = 8'd3; penalty = 17'd2; age_step = 17'd3; manualWin = 4'd4;
    tick();
    load_valid = 1'b1; load_idx = 4'd2; load_bid = 17'h55; rounds = 8'd1;
    checkOutput("run_ready_busy", 32'(load_ready), 32'd0);
    for (int t = 1; t <= 5; t++) tick();
    checkOutput("run_done_E5", 32'(done), 32'd0);
    checkOutput("run_busy_E5", 32'(busy), 32'd1);
    load_valid = 1'b0; start = 1'b0;
    tick();
    checkOutput("run_done_E6", 32'(done), 32'd1);
    checkBids("run_bids", model);
    tick();

    $display("[TB] closed loop, 20 rounds");
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 10; i++) model[i] = '0;
    for (int k = 0; k < 20; k++) begin
      w = argmax(model);
      expQ.push_back(w);
      model = modelUpdate(model, int'(w), 1, 1);
    end
    gBefore = grantsSeen;
    closedLoop = 1'b1;
    start = 1'b1; rounds = 8'd20; penalty = 17'd1; age_step = 17'd1;
    tick();
    start = 1'b0;
    for (int t = 1; t <= 39; t++) tick();
    checkOutput("cl_busy_E39", 32'(busy), 32'd1);
    checkOutput("cl_done_E39", 32'(done), 32'd0);
    tick();
    checkOutput("cl_done_E40", 32'(done), 32'd1);
    checkBids("cl_bids", model);
    tick();
    checkOutput("cl_grants", 32'(grantsSeen - gBefore), 32'd20);
    checkOutput("cl_ready_E41", 32'(load_ready), 32'd1);
    closedLoop = 1'b0;

    $display("[TB] reset during SAMPLE of round 3 of 5");
    expQ.push_back(4'd1);
    expQ.push_back(4'd1);
    start = 1'b1; rounds = 8'd5; penalty = 17'd1; age_step = 17'd1; manualWin = 4'd1;
    tick();
    start = 1'b0;
    for (int t = 1; t <= 5; t++) tick();
    checkOutput("mid_busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    checkReset();
    tick();
    checkOutput("mid_done_held", 32'(done), 32'd0);
    checkOutput("mid_ready_held", 32'(load_ready), 32'd1);
    rst_n = 1'b1;
    tick();
    tick();
    checkOutput("mid_done_after", 32'(done), 32'd0);
    checkOutput("mid_busy_after", 32'(busy), 32'd0);

    checkOutput("queue_empty", 32'(expQ.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
